// File: rtl/trade_history_recorder_pkg.sv
// Shared constants and helpers for the trade history recorder.
// Price width, empty-book sentinels and a saturating counter increment.
package trade_pkg;

  localparam int unsigned PRICE_W = 8;
  localparam logic [PRICE_W-1:0] BID_EMPTY = 8'd0;
  localparam logic [PRICE_W-1:0] ASK_EMPTY = 8'hFF;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trade_history_recorder_if.sv
// Bus between the matching engine / renderer side and the trade history recorder.
// Master drives engine inputs and read address; slave returns history and statistics.
interface trade_history_recorder_if
  import trade_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic               match_flag;
  logic [PRICE_W-1:0] trade_price;
  logic [PRICE_W-1:0] best_bid;
  logic [PRICE_W-1:0] best_ask;
  logic               sample_en;
  logic               freeze;
  logic               clear;
  logic [AW-1:0]      rd_addr;
  logic [PRICE_W-1:0] rd_data;
  logic               rd_valid;
  logic [AW:0]        fill;
  logic               trade_pulse;
  logic [CNT_W-1:0]   trade_count;
  logic [CNT_W-1:0]   drop_count;
  logic [PRICE_W-1:0] last_price;
  logic [PRICE_W-1:0] hi_price;
  logic [PRICE_W-1:0] lo_price;
  logic [PRICE_W-1:0] spread;

  modport master (
    output match_flag, trade_price, best_bid, best_ask, sample_en, freeze, clear, rd_addr,
    input  rd_data, rd_valid, fill, trade_pulse, trade_count, drop_count,
           last_price, hi_price, lo_price, spread
  );

  modport slave (
    input  match_flag, trade_price, best_bid, best_ask, sample_en, freeze, clear, rd_addr,
    output rd_data, rd_valid, fill, trade_pulse, trade_count, drop_count,
           last_price, hi_price, lo_price, spread
  );

endinterface

// File: rtl/trade_ring_buffer.sv
// Circular price history with age-indexed registered read (age 0 = newest).
// Storage is uncleared; fill masks stale entries after reset.
module trade_ring_buffer
  import trade_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PRICE_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [PRICE_W-1:0]       rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FILL_W = AW + 1;

  logic [PRICE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      phys_c;
  logic               hit_c;

  // Age to physical slot; uses pre-write pointer so same-edge reads see old state.
  always_comb begin
    phys_c = wr_ptr - AW'(1) - rd_addr;
    hit_c  = {1'b0, rd_addr} < fill;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != FILL_W'(DEPTH)) begin
          fill <= fill + FILL_W'(1);
        end
      end
      rd_valid <= hit_c;
      rd_data  <= hit_c ? mem[phys_c] : '0;
    end
  end

endmodule

// File: rtl/trade_history_recorder.sv
// Turns matching-engine matches into trade events, records them in a ring buffer
// and keeps session statistics plus the registered book spread.
module trade_history_recorder
  import trade_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  trade_history_recorder_if.slave bus
);

  logic               prev_match;
  logic               clr_c;
  logic               event_c;
  logic               wr_en_c;
  logic [PRICE_W-1:0] spread_c;

  // A sustained match at an unchanged price is a single trade.
  always_comb begin
    clr_c    = reset | bus.clear;
    event_c  = bus.sample_en & bus.match_flag &
               (~prev_match | (bus.trade_price != bus.last_price));
    wr_en_c  = event_c & ~bus.freeze;
    spread_c = bus.best_ask - bus.best_bid;
    if ((bus.best_bid == BID_EMPTY) || (bus.best_ask == ASK_EMPTY) ||
        (bus.best_ask < bus.best_bid)) begin
      spread_c = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_c) begin
      prev_match      <= 1'b0;
      bus.trade_pulse <= 1'b0;
      bus.trade_count <= '0;
      bus.drop_count  <= '0;
      bus.last_price  <= '0;
      bus.hi_price    <= '0;
      bus.lo_price    <= 8'hFF;
      bus.spread      <= 8'hFF;
    end else begin
      bus.trade_pulse <= event_c;
      if (bus.sample_en) begin
        prev_match <= bus.match_flag;
        bus.spread <= spread_c;
      end
      if (event_c) begin
        bus.trade_count <= CNT_W'(sat_inc(32'(bus.trade_count), CNT_W));
        bus.last_price  <= bus.trade_price;
        if (bus.trade_price > bus.hi_price) bus.hi_price <= bus.trade_price;
        if (bus.trade_price < bus.lo_price) bus.lo_price <= bus.trade_price;
        if (bus.freeze) begin
          bus.drop_count <= CNT_W'(sat_inc(32'(bus.drop_count), CNT_W));
        end
      end
    end
  end

  trade_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .reset    (clr_c),
    .wr_en    (wr_en_c),
    .wr_data  (bus.trade_price),
    .rd_addr  (bus.rd_addr),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .fill     (bus.fill)
  );

endmodule

// File: tb/tb_trade_history_recorder.sv
// Directed bench for trade_history_recorder with a read-result scoreboard
// and a small newest-first history model.
module tb_trade_history_recorder;
  import trade_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct {
    logic [7:0] data;
    logic       valid;
    int         age;
  } rd_exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   pulses;
  int   p0;

  rd_exp_t    sb[$];
  logic [7:0] mdl[$];

  trade_history_recorder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  trade_history_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.trade_pulse === 1'b1) pulses++;
  endtask

  task automatic mdl_write(input logic [7:0] p);
    mdl.push_front(p);
    if (mdl.size() > DEPTH) void'(mdl.pop_back());
  endtask

  task automatic push_read(input int age);
    rd_exp_t e;
    e.age = age;
    if (age < mdl.size()) begin
      e.data  = mdl[age];
      e.valid = 1'b1;
    end else begin
      e.data  = 8'h00;
      e.valid = 1'b0;
    end
    sb.push_back(e);
    bus.rd_addr = AW'(age);
  endtask

  task automatic pop_check();
    rd_exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("rd_data_age%0d", e.age), 32'(bus.rd_data), 32'(e.data));
      chk($sformatf("rd_valid_age%0d", e.age), 32'(bus.rd_valid), 32'(e.valid));
    end
  endtask

  task automatic read_age(input int age);
    push_read(age);
    tick();
    pop_check();
  endtask

  task automatic trade(input logic [7:0] p, input logic frz);
    bus.match_flag  = 1'b1;
    bus.trade_price = p;
    bus.freeze      = frz;
    tick();
    if (!frz) mdl_write(p);
  endtask

  task automatic idle();
    bus.match_flag = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0; pulses = 0;
    reset = 1'b1;
    bus.match_flag = 1'b0; bus.trade_price = '0; bus.best_bid = 8'h00; bus.best_ask = 8'hFF;
    bus.sample_en = 1'b0; bus.freeze = 1'b0; bus.clear = 1'b0; bus.rd_addr = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_fill", 32'(bus.fill), 32'd0);
    chk("rst_count", 32'(bus.trade_count), 32'd0);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);
    chk("rst_lo", 32'(bus.lo_price), 32'hFF);
    chk("rst_hi", 32'(bus.hi_price), 32'd0);
    chk("rst_spread", 32'(bus.spread), 32'hFF);
    chk("rst_pulse", 32'(bus.trade_pulse), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Sustained match at 0x40 for 5 cycles, then 0x42.
    bus.sample_en = 1'b1;
    p0 = pulses;
    bus.match_flag = 1'b1; bus.trade_price = 8'h40;
    for (int i = 0; i < 5; i++) tick();
    mdl_write(8'h40);
    bus.trade_price = 8'h42;
    tick();
    mdl_write(8'h42);
    idle();
    chk("sus_pulses", 32'(pulses - p0), 32'd2);
    chk("sus_count", 32'(bus.trade_count), 32'd2);
    chk("sus_hi", 32'(bus.hi_price), 32'h42);
    chk("sus_lo", 32'(bus.lo_price), 32'h40);
    read_age(0);
    read_age(1);
    read_age(2);

    // Match held with sample_en low must not create events.
    bus.sample_en = 1'b0; bus.match_flag = 1'b1; bus.trade_price = 8'h77;
    tick(); tick();
    chk("noqual_count", 32'(bus.trade_count), 32'd2);
    bus.sample_en = 1'b1;
    idle();

    // Wrap-around: 6 trades 1..6 into a 4-deep ring.
    for (int p = 1; p <= 6; p++) trade(8'(p), 1'b0);
    idle();
    chk("wrap_fill", 32'(bus.fill), 32'd4);
    chk("wrap_count", 32'(bus.trade_count), 32'd8);
    chk("wrap_last", 32'(bus.last_price), 32'd6);
    for (int a = 0; a < 4; a++) read_age(a);

    // Clear mid-stream; the coincident event is lost.
    bus.match_flag = 1'b1; bus.trade_price = 8'h99; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0; bus.match_flag = 1'b0;
    mdl.delete();
    chk("clr_fill", 32'(bus.fill), 32'd0);
    chk("clr_count", 32'(bus.trade_count), 32'd0);
    chk("clr_lo", 32'(bus.lo_price), 32'hFF);
    chk("clr_hi", 32'(bus.hi_price), 32'd0);
    chk("clr_spread", 32'(bus.spread), 32'hFF);
    chk("clr_pulse", 32'(bus.trade_pulse), 32'd0);
    read_age(0);

    // Freeze: 2 written, 3 dropped.
    trade(8'h10, 1'b0);
    trade(8'h20, 1'b0);
    trade(8'h30, 1'b1);
    trade(8'h40, 1'b1);
    trade(8'h50, 1'b1);
    bus.freeze = 1'b0;
    idle();
    chk("frz_fill", 32'(bus.fill), 32'd2);
    chk("frz_drop", 32'(bus.drop_count), 32'd3);
    chk("frz_count", 32'(bus.trade_count), 32'd5);
    chk("frz_last", 32'(bus.last_price), 32'h50);
    chk("frz_hi", 32'(bus.hi_price), 32'h50);
    chk("frz_lo", 32'(bus.lo_price), 32'h10);
    read_age(0);
    read_age(1);
    read_age(2);

    // Spread.
    bus.best_bid = 8'h30; bus.best_ask = 8'h38; tick();
    chk("spr_normal", 32'(bus.spread), 32'h08);
    bus.best_bid = 8'h00; tick();
    chk("spr_bid_empty", 32'(bus.spread), 32'hFF);
    bus.best_bid = 8'h50; bus.best_ask = 8'h48; tick();
    chk("spr_crossed", 32'(bus.spread), 32'hFF);
    bus.best_bid = 8'h10; bus.best_ask = 8'hFF; tick();
    chk("spr_ask_empty", 32'(bus.spread), 32'hFF);
    bus.best_bid = 8'h48; bus.best_ask = 8'h48; tick();
    chk("spr_zero", 32'(bus.spread), 32'h00);
    bus.sample_en = 1'b0; bus.best_bid = 8'h20; bus.best_ask = 8'h30; tick();
    chk("spr_hold", 32'(bus.spread), 32'h00);
    bus.sample_en = 1'b1;

    // Same-edge write and read: age 0 returns the previous newest.
    push_read(0);
    bus.match_flag = 1'b1; bus.trade_price = 8'h55; bus.freeze = 1'b0;
    tick();
    pop_check();
    mdl_write(8'h55);
    chk("se_pulse", 32'(bus.trade_pulse), 32'd1);
    bus.match_flag = 1'b0;
    read_age(0);
    read_age(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
